// File: rtl/core_hazard_ctrl_if.sv
// rtl/core_hazard_ctrl_if.sv - decode hazard bus, cache acks and pipeline control signals of the hazard controller
interface core_hazard_ctrl_if #(
  parameter int REG_AW    = 5,
  parameter int HZ_TYPE_W = 2
);
  logic [3*REG_AW-1:0]  hz_dec_bus;
  logic [HZ_TYPE_W-1:0] hz_dec_type;
  logic                 hz_dec_we;
  logic                 hz_dec_valid;
  logic                 il1_ack;
  logic                 dl1_req_mem;
  logic                 dl1_ack;
  logic                 exe_brnch_taken;
  logic                 pc_enb;
  logic                 if_kill;
  logic                 dec_enb;
  logic                 dec_kill;
  logic                 dec_nop_gen;
  logic                 pipe_enb;
  logic [1:0]           fwd_src1_sel;
  logic [1:0]           fwd_src2_sel;
  logic [2:0]           hz_state;

  // pipeline side: presents the DEC instruction and cache status, obeys the controls
  modport master (
    output hz_dec_bus, hz_dec_type, hz_dec_we, hz_dec_valid,
    output il1_ack, dl1_req_mem, dl1_ack, exe_brnch_taken,
    input  pc_enb, if_kill, dec_enb, dec_kill, dec_nop_gen, pipe_enb,
    input  fwd_src1_sel, fwd_src2_sel, hz_state
  );

  // controller side
  modport slave (
    input  hz_dec_bus, hz_dec_type, hz_dec_we, hz_dec_valid,
    input  il1_ack, dl1_req_mem, dl1_ack, exe_brnch_taken,
    output pc_enb, if_kill, dec_enb, dec_kill, dec_nop_gen, pipe_enb,
    output fwd_src1_sel, fwd_src2_sel, hz_state
  );
endinterface

// File: rtl/core_hazard_ctrl.sv
// rtl/core_hazard_ctrl.sv - 5-stage pipeline hazard sequencer and forwarding select (optional macro CORE_HZRD_FWD_EN)
module core_hazard_ctrl #(
  parameter int REG_AW    = 5,
  parameter int HZ_TYPE_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  core_hazard_ctrl_if.slave hz_if
);

`ifdef CORE_HZRD_FWD_EN
  localparam logic [HZ_TYPE_W-1:0] HZRD_LOAD  = HZ_TYPE_W'(1);
`endif
  localparam logic [HZ_TYPE_W-1:0] HZRD_BRNCH = HZ_TYPE_W'(2);
  localparam logic [HZ_TYPE_W-1:0] HZRD_JUMP  = HZ_TYPE_W'(3);

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_LD_STALL = 3'd1,
    ST_FLUSH    = 3'd2,
    ST_MEM_WAIT = 3'd3,
    ST_IF_WAIT  = 3'd4
  } state_e;

  typedef struct packed {
    logic                 v;
    logic                 we;
    logic [HZ_TYPE_W-1:0] ty;
    logic [REG_AW-1:0]    rd;
  } sb_entry_t;

  // index 0 = EXE, 1 = MEM, 2 = WB
  sb_entry_t         sb_q [3];
  sb_entry_t         sb_d [3];
  state_e            state_q, state_d;
  sb_entry_t         dec_entry;
  logic [REG_AW-1:0] rs1, rs2, rd;
  logic              mem_wait, exe_redirect, ld_use;
  logic              pc_enb, if_kill, dec_enb, dec_kill, dec_nop_gen, pipe_enb;
  logic [1:0]        fwd1_sel, fwd2_sel;

  function automatic logic sb_match(input sb_entry_t e, input logic [REG_AW-1:0] rs);
    return e.v && e.we && (e.rd != '0) && (e.rd == rs);
  endfunction

  assign rs1       = hz_if.hz_dec_bus[3*REG_AW-1 -: REG_AW];
  assign rs2       = hz_if.hz_dec_bus[2*REG_AW-1 -: REG_AW];
  assign rd        = hz_if.hz_dec_bus[REG_AW-1:0];
  assign dec_entry = {hz_if.hz_dec_valid, hz_if.hz_dec_we, hz_if.hz_dec_type, rd};

  assign mem_wait = hz_if.dl1_req_mem && !hz_if.dl1_ack;

  // A redirect kills the EXE slot, so a second FLUSH in a row would be acting on a bubble
  assign exe_redirect = sb_q[0].v && (state_q != ST_FLUSH) &&
                        ((sb_q[0].ty == HZRD_JUMP) ||
                         ((sb_q[0].ty == HZRD_BRNCH) && hz_if.exe_brnch_taken));

`ifdef CORE_HZRD_FWD_EN
  // Only a load result still in EXE cannot be forwarded in time
  assign ld_use = hz_if.hz_dec_valid && (sb_q[0].ty == HZRD_LOAD) &&
                  (sb_match(sb_q[0], rs1) || sb_match(sb_q[0], rs2));

  function automatic logic [1:0] fwd_pick(input logic [REG_AW-1:0] rs, input sb_entry_t e_exe,
                                          input sb_entry_t e_mem, input sb_entry_t e_wb);
    logic [1:0] sel;
    sel = 2'd0;
    if (sb_match(e_wb, rs))                               sel = 2'd3;
    if (sb_match(e_mem, rs))                              sel = 2'd2;
    if (sb_match(e_exe, rs) && (e_exe.ty != HZRD_LOAD))   sel = 2'd1;
    return sel;
  endfunction
`else
  logic any_match;

  // Without forwarding every in-flight writer of a source blocks DEC until it retires
  always_comb begin
    any_match = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (sb_match(sb_q[i], rs1) || sb_match(sb_q[i], rs2)) any_match = 1'b1;
    end
  end

  assign ld_use = hz_if.hz_dec_valid && any_match;
`endif

  // Priority-ordered next state and the pipeline controls that go with it
  always_comb begin
    state_d     = ST_RUN;
    pc_enb      = 1'b1;
    dec_enb     = 1'b1;
    pipe_enb    = 1'b1;
    if_kill     = 1'b0;
    dec_kill    = 1'b0;
    dec_nop_gen = 1'b0;
    if (mem_wait)           state_d = ST_MEM_WAIT;
    else if (exe_redirect)  state_d = ST_FLUSH;
    else if (ld_use)        state_d = ST_LD_STALL;
    else if (!hz_if.il1_ack) state_d = ST_IF_WAIT;
    case (state_d)
      ST_MEM_WAIT: begin
        pc_enb   = 1'b0;
        dec_enb  = 1'b0;
        pipe_enb = 1'b0;
      end
      ST_FLUSH: begin
        if_kill  = 1'b1;
        dec_kill = 1'b1;
      end
      ST_LD_STALL, ST_IF_WAIT: begin
        pc_enb      = 1'b0;
        dec_nop_gen = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      state_d     = ST_RUN;
      pc_enb      = 1'b0;
      dec_enb     = 1'b0;
      pipe_enb    = 1'b0;
      if_kill     = 1'b1;
      dec_kill    = 1'b1;
      dec_nop_gen = 1'b1;
    end
  end

  // Forwarding selects for the two DEC source operands
  always_comb begin
    fwd1_sel = 2'd0;
    fwd2_sel = 2'd0;
`ifdef CORE_HZRD_FWD_EN
    if (!rst) begin
      fwd1_sel = fwd_pick(rs1, sb_q[0], sb_q[1], sb_q[2]);
      fwd2_sel = fwd_pick(rs2, sb_q[0], sb_q[1], sb_q[2]);
    end
`endif
  end

  // Scoreboard shifts with the back end; EXE only picks up a real, unsuppressed DEC instruction
  always_comb begin
    sb_d = sb_q;
    if (pipe_enb) begin
      sb_d[2] = sb_q[1];
      sb_d[1] = sb_q[0];
      sb_d[0] = '0;
      if (dec_enb && !dec_nop_gen && !dec_kill && hz_if.hz_dec_valid) sb_d[0] = dec_entry;
    end
  end

  // State and scoreboard registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      for (int i = 0; i < 3; i++) sb_q[i] <= '0;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < 3; i++) sb_q[i] <= sb_d[i];
    end
  end

  assign hz_if.pc_enb       = pc_enb;
  assign hz_if.if_kill      = if_kill;
  assign hz_if.dec_enb      = dec_enb;
  assign hz_if.dec_kill     = dec_kill;
  assign hz_if.dec_nop_gen  = dec_nop_gen;
  assign hz_if.pipe_enb     = pipe_enb;
  assign hz_if.fwd_src1_sel = fwd1_sel;
  assign hz_if.fwd_src2_sel = fwd2_sel;
  assign hz_if.hz_state     = state_d;

endmodule

// File: tb/tb_core_hazard_ctrl.sv
// tb/tb_core_hazard_ctrl.sv - directed and randomized checks of core_hazard_ctrl against an in-bench pipeline model
module tb_core_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;

  core_hazard_ctrl_if hz_if ();

  core_hazard_ctrl dut (
    .clk   (clk),
    .rst   (rst),
    .hz_if (hz_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v;
    bit we;
    int ty;
    int rd;
  } ent_t;

  // model of the instructions in EXE, MEM, WB
  ent_t stage [3];
  int   checks = 0;
  int   errors = 0;
  int   cur_ty, cur_s1, cur_s2, cur_d;
  bit   cur_vld, cur_we, cur_il1, cur_dreq, cur_dack, cur_tkn;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit writes(input ent_t e, input int rs);
    return e.v && e.we && (e.rd != 0) && (e.rd == rs);
  endfunction

  task automatic model_check();
    int st, e_pc, e_dec, e_pipe, e_ifk, e_deck, e_nop, e_f1, e_f2;
    bit redirect, stall;
    if (rst) begin
      st = 0; e_pc = 0; e_dec = 0; e_pipe = 0; e_ifk = 1; e_deck = 1; e_nop = 1; e_f1 = 0; e_f2 = 0;
    end else begin
      redirect = stage[0].v && (stage[0].ty == 3 || (stage[0].ty == 2 && cur_tkn));
      stall = 0;
`ifdef CORE_HZRD_FWD_EN
      if (cur_vld && stage[0].ty == 1 && (writes(stage[0], cur_s1) || writes(stage[0], cur_s2))) stall = 1;
`else
      for (int i = 0; i < 3; i++)
        if (cur_vld && (writes(stage[i], cur_s1) || writes(stage[i], cur_s2))) stall = 1;
`endif
      if (cur_dreq && !cur_dack) st = 3;
      else if (redirect)         st = 2;
      else if (stall)            st = 1;
      else if (!cur_il1)         st = 4;
      else                       st = 0;
      e_pc   = (st == 0 || st == 2) ? 1 : 0;
      e_dec  = (st == 3) ? 0 : 1;
      e_pipe = (st == 3) ? 0 : 1;
      e_ifk  = (st == 2) ? 1 : 0;
      e_deck = (st == 2) ? 1 : 0;
      e_nop  = (st == 1 || st == 4) ? 1 : 0;
      e_f1 = 0;
      e_f2 = 0;
`ifdef CORE_HZRD_FWD_EN
      for (int i = 2; i >= 0; i--) begin
        if (!(i == 0 && stage[0].ty == 1)) begin
          if (writes(stage[i], cur_s1)) e_f1 = i + 1;
          if (writes(stage[i], cur_s2)) e_f2 = i + 1;
        end
      end
`endif
    end
    chk("hz_state", hz_if.hz_state, st);
    chk("pc_enb", hz_if.pc_enb, e_pc);
    chk("dec_enb", hz_if.dec_enb, e_dec);
    chk("pipe_enb", hz_if.pipe_enb, e_pipe);
    chk("if_kill", hz_if.if_kill, e_ifk);
    chk("dec_kill", hz_if.dec_kill, e_deck);
    chk("dec_nop_gen", hz_if.dec_nop_gen, e_nop);
    chk("fwd_src1_sel", hz_if.fwd_src1_sel, e_f1);
    chk("fwd_src2_sel", hz_if.fwd_src2_sel, e_f2);
    // advance the model to the next cycle
    if (rst) begin
      for (int i = 0; i < 3; i++) stage[i] = '{0, 0, 0, 0};
    end else if (e_pipe == 1) begin
      stage[2] = stage[1];
      stage[1] = stage[0];
      if (cur_vld && e_dec == 1 && e_nop == 0 && e_deck == 0)
        stage[0] = '{1, cur_we, cur_ty, cur_d};
      else
        stage[0] = '{0, 0, 0, 0};
    end
  endtask

  task automatic drive(input bit r, input bit vld, input int ty, input bit we, input int s1,
                       input int s2, input int d, input bit il1, input bit dreq, input bit dack,
                       input bit tkn);
    @(posedge clk);
    #1;
    rst = r;
    cur_vld = vld; cur_ty = ty; cur_we = we; cur_s1 = s1; cur_s2 = s2; cur_d = d;
    cur_il1 = il1; cur_dreq = dreq; cur_dack = dack; cur_tkn = tkn;
    hz_if.hz_dec_bus      = {5'(s1), 5'(s2), 5'(d)};
    hz_if.hz_dec_type     = 2'(ty);
    hz_if.hz_dec_we       = we;
    hz_if.hz_dec_valid    = vld;
    hz_if.il1_ack         = il1;
    hz_if.dl1_req_mem     = dreq;
    hz_if.dl1_ack         = dack;
    hz_if.exe_brnch_taken = tkn;
    #4;
    model_check();
  endtask

  task automatic idle(input bit dreq, input bit dack, input bit tkn);
    drive(0, 0, 0, 0, 0, 0, 0, 1, dreq, dack, tkn);
  endtask

  initial begin
    rst = 1'b1;
    hz_if.hz_dec_bus = '0; hz_if.hz_dec_type = '0; hz_if.hz_dec_we = 1'b0;
    hz_if.hz_dec_valid = 1'b0; hz_if.il1_ack = 1'b1; hz_if.dl1_req_mem = 1'b0;
    hz_if.dl1_ack = 1'b0; hz_if.exe_brnch_taken = 1'b0;
    for (int i = 0; i < 3; i++) stage[i] = '{0, 0, 0, 0};

    // reset
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      chk("rst_dec_kill", hz_if.dec_kill, 1);
      chk("rst_pc_enb", hz_if.pc_enb, 0);
    end

    // LOAD rd=5, then add rs1=5
    drive(0, 1, 1, 1, 0, 0, 5, 1, 0, 0, 0);
    chk("run_state", hz_if.hz_state, 0);
    chk("run_pc_enb", hz_if.pc_enb, 1);
    drive(0, 1, 0, 1, 5, 0, 6, 1, 0, 0, 0);
    chk("ld_use_nop", hz_if.dec_nop_gen, 1);
    chk("ld_use_pc", hz_if.pc_enb, 0);
    chk("ld_use_state", hz_if.hz_state, 1);
    drive(0, 1, 0, 1, 5, 0, 6, 1, 0, 0, 0);
`ifdef CORE_HZRD_FWD_EN
    chk("ld_use_fwd_mem", hz_if.fwd_src1_sel, 2);
    chk("ld_use_done", hz_if.hz_state, 0);
`else
    chk("nofwd_stall2", hz_if.hz_state, 1);
    drive(0, 1, 0, 1, 5, 0, 6, 1, 0, 0, 0);
    chk("nofwd_stall3", hz_if.hz_state, 1);
    drive(0, 1, 0, 1, 5, 0, 6, 1, 0, 0, 0);
    chk("nofwd_release", hz_if.hz_state, 0);
    chk("nofwd_sel", hz_if.fwd_src1_sel, 0);
`endif
    for (int i = 0; i < 3; i++) idle(0, 0, 0);

    // add rd=7, then rs2=7
    drive(0, 1, 0, 1, 0, 0, 7, 1, 0, 0, 0);
    drive(0, 1, 0, 1, 0, 7, 8, 1, 0, 0, 0);
`ifdef CORE_HZRD_FWD_EN
    chk("raw_fwd_exe", hz_if.fwd_src2_sel, 1);
    chk("raw_no_stall", hz_if.hz_state, 0);
`else
    chk("raw_stall", hz_if.hz_state, 1);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 1, 0, 7, 8, 1, 0, 0, 0);
`endif
    for (int i = 0; i < 4; i++) idle(0, 0, 0);

    // JUMP held in EXE by a 4-cycle dl1 wait, flushes on the ack cycle
    drive(0, 1, 3, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      idle(1, 0, 0);
      chk("memwait_pipe", hz_if.pipe_enb, 0);
      chk("memwait_state", hz_if.hz_state, 3);
    end
    idle(1, 1, 0);
    chk("ack_flush_state", hz_if.hz_state, 2);
    chk("ack_flush_ifkill", hz_if.if_kill, 1);
    idle(0, 0, 0);
    chk("flush_one_cycle", hz_if.hz_state, 0);

    // branch not taken, then taken
    drive(0, 1, 2, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(0, 0, 0);
    chk("brnch_nt", hz_if.hz_state, 0);
    drive(0, 1, 2, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(0, 0, 1);
    chk("brnch_t", hz_if.hz_state, 2);
    chk("brnch_t_deckill", hz_if.dec_kill, 1);

    // rd=0 writer then fetch stall with rs=0
    drive(0, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 0, 1, 0, 0, 3, 0, 0, 0, 0);
      chk("ifwait_state", hz_if.hz_state, 4);
      chk("ifwait_nop", hz_if.dec_nop_gen, 1);
    end

    // randomized traffic with a small register set so hazards are frequent
    for (int n = 0; n < 4000; n++) begin
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 8, $urandom_range(0, 3),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 19) < 17, $urandom_range(0, 3) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
